// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time between execute and a req/ack word bus.
// Handles lane select, replication, sign/zero extension, alignment and bus timeout.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUS = 2'd1, S_RESP = 2'd2} state_t;

  state_t      r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [2:0]  r_f3;
  logic        r_we, r_err;

  logic        w_illegal, w_tmo;
  logic [31:0] w_lane, w_ext;

  // funct3[1:0] is the access size for both loads and stores; funct3[2] marks unsigned loads
  always_comb begin
    w_illegal = 1'b0;
    if (req_we) w_illegal = (req_funct3 > 3'd2);
    else        w_illegal = (req_funct3 == 3'd3) || (req_funct3 >= 3'd6);
    if (req_funct3[1:0] == 2'd1 && req_addr[0])          w_illegal = 1'b1;
    if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0) w_illegal = 1'b1;
  end

  assign w_tmo  = (r_cnt == CW'(TIMEOUT - 1));
  assign w_lane = mem_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ext = w_lane;
    case (r_f3)
      3'd0:    w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'd1:    w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'd4:    w_ext = {24'd0, w_lane[7:0]};
      3'd5:    w_ext = {16'd0, w_lane[15:0]};
      default: w_ext = w_lane;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = w_illegal ? S_RESP : S_BUS;
      S_BUS:   if (mem_ack || w_tmo) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_f3    <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_f3    <= req_funct3;
          r_we    <= req_we;
          r_err   <= w_illegal;
          r_rdata <= '0;
          r_cnt   <= '0;
        end
        S_BUS: if (mem_ack) begin
          r_rdata <= r_we ? 32'd0 : w_ext;
          r_err   <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          if (w_tmo) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // bus and response outputs are gated by state so they read zero outside their window
  always_comb begin
    stall     = req_valid && (r_state != S_RESP);
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (r_state == S_BUS) begin
      mem_req  = 1'b1;
      mem_we   = r_we;
      mem_addr = {r_addr[31:2], 2'b00};
      case (r_f3[1:0])
        2'd0: begin
          mem_be    = 4'b0001 << r_addr[1:0];
          mem_wdata = {4{r_wdata[7:0]}};
        end
        2'd1: begin
          mem_be    = 4'b0011 << r_addr[1:0];
          mem_wdata = {2{r_wdata[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = r_wdata;
        end
      endcase
    end
    if (r_state == S_RESP) begin
      rsp_valid = 1'b1;
      rsp_err   = r_err;
      rsp_rdata = r_rdata;
    end
  end

endmodule
